// File: rtl/pcie_us_msi_pkg.sv
// Shared definitions for the multi-function MSI request engine:
// FSM states, MSI geometry and the vector fold into the host-allocated range.
package pcie_us_msi_pkg;

    localparam int unsigned MSI_VEC  = 32;
    localparam int unsigned MMEN_W   = 3;
    localparam int unsigned MAX_MMEN = 5;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_BACKOFF
    } msi_state_e;

    // Host grants 1<<mm vectors (mm capped at 5); the vector folds into that range.
    function automatic logic [MSI_VEC-1:0] fold_vec(input logic [4:0] vec,
                                                    input logic [MMEN_W-1:0] mm);
        logic [MMEN_W-1:0] m;
        logic [5:0]        alloc;
        logic [MSI_VEC-1:0] onehot;
        m      = (mm > MMEN_W'(MAX_MMEN)) ? MMEN_W'(MAX_MMEN) : mm;
        alloc  = 6'd1 << m;
        onehot = '0;
        onehot[vec & 5'(alloc - 6'd1)] = 1'b1;
        return onehot;
    endfunction

endpackage

// File: rtl/pcie_us_msi_multi_if.sv
// MSI interrupt port of the UltraScale+ PCIe hard core (cfg_interrupt_msi_*).
// master = request engine, slave = hard core.
interface pcie_us_msi_multi_if;

    logic [31:0] cfg_interrupt_msi_int;
    logic [3:0]  cfg_interrupt_msi_function_number;
    logic        cfg_interrupt_msi_sent;
    logic        cfg_interrupt_msi_fail;
    logic [3:0]  cfg_interrupt_msi_enable;
    logic [11:0] cfg_interrupt_msi_mmenable;
    logic [3:0]  cfg_interrupt_msi_select;
    logic [2:0]  cfg_interrupt_msi_attr;
    logic        cfg_interrupt_msi_tph_present;
    logic [1:0]  cfg_interrupt_msi_tph_type;
    logic [7:0]  cfg_interrupt_msi_tph_st_tag;
    logic [31:0] cfg_interrupt_msi_pending_status;
    logic        cfg_interrupt_msi_pending_status_data_enable;
    logic [3:0]  cfg_interrupt_msi_pending_status_function_num;

    modport master (
        output cfg_interrupt_msi_int,
        output cfg_interrupt_msi_function_number,
        output cfg_interrupt_msi_select,
        output cfg_interrupt_msi_attr,
        output cfg_interrupt_msi_tph_present,
        output cfg_interrupt_msi_tph_type,
        output cfg_interrupt_msi_tph_st_tag,
        output cfg_interrupt_msi_pending_status,
        output cfg_interrupt_msi_pending_status_data_enable,
        output cfg_interrupt_msi_pending_status_function_num,
        input  cfg_interrupt_msi_sent,
        input  cfg_interrupt_msi_fail,
        input  cfg_interrupt_msi_enable,
        input  cfg_interrupt_msi_mmenable
    );

    modport slave (
        input  cfg_interrupt_msi_int,
        input  cfg_interrupt_msi_function_number,
        input  cfg_interrupt_msi_select,
        input  cfg_interrupt_msi_attr,
        input  cfg_interrupt_msi_tph_present,
        input  cfg_interrupt_msi_tph_type,
        input  cfg_interrupt_msi_tph_st_tag,
        input  cfg_interrupt_msi_pending_status,
        input  cfg_interrupt_msi_pending_status_data_enable,
        input  cfg_interrupt_msi_pending_status_function_num,
        output cfg_interrupt_msi_sent,
        output cfg_interrupt_msi_fail,
        output cfg_interrupt_msi_enable,
        output cfg_interrupt_msi_mmenable
    );

endinterface

// File: rtl/pcie_us_msi_multi_priority_encoder.sv
// Combinational priority encoder: index of the winning request bit,
// lowest index wins when LSB_HIGH_PRIORITY is set, highest otherwise.
module priority_encoder #(
    parameter int unsigned WIDTH             = 32,
    parameter bit          LSB_HIGH_PRIORITY = 1'b1
) (
    input  logic [WIDTH-1:0]         req_i,
    output logic                     valid_o,
    output logic [$clog2(WIDTH)-1:0] idx_o
);

    localparam int unsigned IDX_W = $clog2(WIDTH);

    always_comb begin
        valid_o = |req_i;
        idx_o   = '0;
        if (LSB_HIGH_PRIORITY) begin
            for (int unsigned i = WIDTH; i > 0; i--) begin
                if (req_i[i-1]) idx_o = IDX_W'(i - 1);
            end
        end else begin
            for (int unsigned i = 0; i < WIDTH; i++) begin
                if (req_i[i]) idx_o = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/pcie_us_msi_multi.sv
// Multi-function, multi-vector MSI request engine: latches events, arbitrates
// round-robin across functions, folds vectors and retries on fail/timeout.
module pcie_us_msi_multi
    import pcie_us_msi_pkg::*;
#(
    parameter int unsigned NUM_FUNC     = 1,
    parameter int unsigned WAIT_TIMEOUT = 64,
    parameter int unsigned RETRY_DELAY  = 16,
    parameter int unsigned MAX_RETRIES  = 3
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_FUNC*MSI_VEC-1:0] irq_in,
    output logic [NUM_FUNC*MSI_VEC-1:0] irq_pending,
    output logic                        irq_drop,
    pcie_us_msi_multi_if.master         msi
);

    localparam int unsigned PEND_W  = NUM_FUNC * MSI_VEC;
    localparam int unsigned TMR_MAX = (WAIT_TIMEOUT > RETRY_DELAY) ? WAIT_TIMEOUT : RETRY_DELAY;
    localparam int unsigned TMR_W   = $clog2(TMR_MAX + 1);
    localparam int unsigned RTY_W   = $clog2(MAX_RETRIES + 1);
    localparam int unsigned VEC_W   = $clog2(MSI_VEC);

    msi_state_e          state_q;
    logic [PEND_W-1:0]   pending_q, pending_d, clr_mask;
    logic [1:0]          func_q, rr_q, arb_func, rr_next;
    logic [VEC_W-1:0]    vec_q, pe_idx;
    logic [TMR_W-1:0]    tmr_q;
    logic [RTY_W-1:0]    retry_q;
    logic [MSI_VEC-1:0]  int_q, pe_req;
    logic [3:0]          fnum_q;
    logic                drop_q;
    logic [NUM_FUNC-1:0] elig;
    logic                arb_valid, pe_valid;
    logic [MMEN_W-1:0]   arb_mm, cur_mm;
    logic                wait_sent, wait_fail, give_up;
    logic                unused_cfg;

    always_comb begin
        for (int unsigned f = 0; f < NUM_FUNC; f++) begin
            elig[f] = msi.cfg_interrupt_msi_enable[f] & (|pending_q[f*MSI_VEC +: MSI_VEC]);
        end
    end

    // Scan from rr_q upward; descending loop so the closest eligible function wins.
    always_comb begin
        arb_valid = 1'b0;
        arb_func  = rr_q;
        for (int unsigned k = NUM_FUNC; k > 0; k--) begin
            if (elig[(32'(rr_q) + k - 1) % NUM_FUNC]) begin
                arb_valid = 1'b1;
                arb_func  = 2'((32'(rr_q) + k - 1) % NUM_FUNC);
            end
        end
    end

    always_comb begin
        pe_req = '0;
        arb_mm = '0;
        cur_mm = '0;
        for (int unsigned f = 0; f < NUM_FUNC; f++) begin
            if (32'(arb_func) == f) begin
                pe_req = pending_q[f*MSI_VEC +: MSI_VEC];
                arb_mm = msi.cfg_interrupt_msi_mmenable[f*MMEN_W +: MMEN_W];
            end
            if (32'(func_q) == f) begin
                cur_mm = msi.cfg_interrupt_msi_mmenable[f*MMEN_W +: MMEN_W];
            end
        end
    end

    priority_encoder #(
        .WIDTH            (MSI_VEC),
        .LSB_HIGH_PRIORITY(1'b1)
    ) u_vec_pe (
        .req_i  (pe_req),
        .valid_o(pe_valid),
        .idx_o  (pe_idx)
    );

    always_comb begin
        rr_next   = (32'(func_q) == NUM_FUNC - 1) ? 2'd0 : func_q + 2'd1;
        wait_sent = (state_q == ST_WAIT) && msi.cfg_interrupt_msi_sent;
        wait_fail = (state_q == ST_WAIT) && !msi.cfg_interrupt_msi_sent &&
                    (msi.cfg_interrupt_msi_fail || tmr_q == TMR_W'(WAIT_TIMEOUT - 1));
        give_up   = wait_fail && (retry_q == RTY_W'(MAX_RETRIES - 1));
        clr_mask  = '0;
        if (wait_sent || give_up) clr_mask[32'(func_q)*MSI_VEC + 32'(vec_q)] = 1'b1;
        // OR-in after the clear so a fresh event on the same bit survives.
        pending_d = (pending_q & ~clr_mask) | irq_in;
    end

    always_ff @(posedge clk) begin
        if (rst) pending_q <= '0;
        else     pending_q <= pending_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            func_q  <= '0;
            vec_q   <= '0;
            rr_q    <= '0;
            tmr_q   <= '0;
            retry_q <= '0;
            int_q   <= '0;
            fnum_q  <= '0;
            drop_q  <= 1'b0;
        end else begin
            int_q  <= '0;
            fnum_q <= '0;
            drop_q <= 1'b0;
            unique case (state_q)
                ST_IDLE: begin
                    if (arb_valid) begin
                        func_q  <= arb_func;
                        vec_q   <= pe_idx;
                        int_q   <= fold_vec(pe_idx, arb_mm);
                        fnum_q  <= 4'(arb_func);
                        state_q <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    tmr_q   <= '0;
                    state_q <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (wait_sent) begin
                        retry_q <= '0;
                        rr_q    <= rr_next;
                        state_q <= ST_IDLE;
                    end else if (wait_fail) begin
                        tmr_q <= '0;
                        if (give_up) begin
                            retry_q <= '0;
                            drop_q  <= 1'b1;
                            state_q <= ST_IDLE;
                        end else begin
                            retry_q <= retry_q + RTY_W'(1);
                            state_q <= ST_BACKOFF;
                        end
                    end else if (tmr_q != '1) begin
                        tmr_q <= tmr_q + TMR_W'(1);
                    end
                end
                ST_BACKOFF: begin
                    // Reissue the latched request regardless of the current enable.
                    if (tmr_q == TMR_W'(RETRY_DELAY - 1)) begin
                        int_q   <= fold_vec(vec_q, cur_mm);
                        fnum_q  <= 4'(func_q);
                        state_q <= ST_ISSUE;
                    end else if (tmr_q != '1) begin
                        tmr_q <= tmr_q + TMR_W'(1);
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign irq_pending = pending_q;
    assign irq_drop    = drop_q;

    assign msi.cfg_interrupt_msi_int                        = int_q;
    assign msi.cfg_interrupt_msi_function_number            = fnum_q;
    assign msi.cfg_interrupt_msi_select                     = '0;
    assign msi.cfg_interrupt_msi_attr                       = '0;
    assign msi.cfg_interrupt_msi_tph_present                = 1'b0;
    assign msi.cfg_interrupt_msi_tph_type                   = '0;
    assign msi.cfg_interrupt_msi_tph_st_tag                 = '0;
    assign msi.cfg_interrupt_msi_pending_status             = '0;
    assign msi.cfg_interrupt_msi_pending_status_data_enable = 1'b0;
    assign msi.cfg_interrupt_msi_pending_status_function_num = '0;

    assign unused_cfg = ^{msi.cfg_interrupt_msi_enable, msi.cfg_interrupt_msi_mmenable, pe_valid};

endmodule

// File: tb/tb_pcie_us_msi_multi.sv
// Scoreboard bench for pcie_us_msi_multi (2 functions, short timers): expected
// MSI requests are queued by the stimulus and checked by an independent monitor.
module tb_pcie_us_msi_multi;

    localparam int unsigned NF = 2;
    localparam int unsigned WT = 8;
    localparam int unsigned RD = 4;
    localparam int unsigned MR = 3;

    typedef struct {
        logic [31:0] vec;
        logic [3:0]  fn;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [63:0] irq_in = '0;
    logic [63:0] irq_pending;
    logic        irq_drop;

    exp_t exp_q[$];
    exp_t mon_e;
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    int   drop_seen = 0;

    pcie_us_msi_multi_if bus ();

    pcie_us_msi_multi #(
        .NUM_FUNC    (NF),
        .WAIT_TIMEOUT(WT),
        .RETRY_DELAY (RD),
        .MAX_RETRIES (MR)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .irq_in     (irq_in),
        .irq_pending(irq_pending),
        .irq_drop   (irq_drop),
        .msi        (bus.master)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (bus.cfg_interrupt_msi_int != '0) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_int", 64'(bus.cfg_interrupt_msi_int), 64'h0);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("msi_int", 64'(bus.cfg_interrupt_msi_int), 64'(mon_e.vec));
                    chk("func_num", 64'(bus.cfg_interrupt_msi_function_number), 64'(mon_e.fn));
                end
            end
            if (irq_drop) drop_seen++;
        end
    end

    task automatic push(input logic [31:0] v, input logic [3:0] f);
        exp_t e;
        e.vec = v;
        e.fn  = f;
        exp_q.push_back(e);
    endtask

    task automatic pulse_irq(input logic [63:0] m, output int c);
        @(negedge clk);
        irq_in = m;
        c = cyc;
        @(negedge clk);
        irq_in = '0;
    endtask

    task automatic wait_int(output int c);
        c = -1;
        for (int n = 0; n < 100; n++) begin
            @(negedge clk);
            if (bus.cfg_interrupt_msi_int != '0) begin
                c = cyc;
                return;
            end
        end
        total++;
        bad++;
        $display("FAIL int_wait: no msi_int pulse within 100 cycles");
    endtask

    task automatic respond(input logic s, input logic f, input int dly);
        repeat (dly) @(negedge clk);
        bus.cfg_interrupt_msi_sent = s;
        bus.cfg_interrupt_msi_fail = f;
        @(negedge clk);
        bus.cfg_interrupt_msi_sent = 1'b0;
        bus.cfg_interrupt_msi_fail = 1'b0;
    endtask

    task automatic set_mm(input logic [2:0] m0, input logic [2:0] m1);
        bus.cfg_interrupt_msi_mmenable = {6'b0, m1, m0};
    endtask

    // mm, vector (function 0), expected one-hot after folding
    logic [2:0]  tv_mm  [5] = '{3'd5, 3'd2, 3'd7, 3'd0, 3'd3};
    int          tv_vec [5] = '{3, 6, 20, 13, 15};
    logic [31:0] tv_exp [5] = '{32'h8, 32'h4, 32'h0010_0000, 32'h1, 32'h80};

    initial begin
        int k, c, c1, c2, c3, d0;
        bus.cfg_interrupt_msi_sent     = 1'b0;
        bus.cfg_interrupt_msi_fail     = 1'b0;
        bus.cfg_interrupt_msi_enable   = 4'b0011;
        set_mm(3'd5, 3'd5);

        repeat (3) @(negedge clk);
        chk("rst_pending", irq_pending, 64'h0);
        chk("rst_int", 64'(bus.cfg_interrupt_msi_int), 64'h0);
        chk("rst_fnum", 64'(bus.cfg_interrupt_msi_function_number), 64'h0);
        chk("rst_drop", 64'(irq_drop), 64'h0);
        chk("const_outs", 64'({bus.cfg_interrupt_msi_select, bus.cfg_interrupt_msi_attr,
                                bus.cfg_interrupt_msi_tph_present, bus.cfg_interrupt_msi_tph_type,
                                bus.cfg_interrupt_msi_tph_st_tag,
                                bus.cfg_interrupt_msi_pending_status_data_enable,
                                bus.cfg_interrupt_msi_pending_status_function_num})
                       | 64'(bus.cfg_interrupt_msi_pending_status), 64'h0);
        rst = 1'b0;

        // Single-function vectors, latency irq->pending->int of 2 cycles, fold table
        for (int i = 0; i < 5; i++) begin
            set_mm(tv_mm[i], 3'd5);
            push(tv_exp[i], 4'd0);
            pulse_irq(64'h1 << tv_vec[i], k);
            chk("pending_set", irq_pending, 64'h1 << tv_vec[i]);
            wait_int(c);
            chk("latency", 64'(c - k), 64'd2);
            respond(1'b1, 1'b0, 3);
            chk("pending_cleared", irq_pending, 64'h0);
        end

        // Fresh RR pointer: f0 and f1 together, f0 first
        @(negedge clk); rst = 1'b1;
        repeat (2) @(negedge clk); rst = 1'b0;
        set_mm(3'd5, 3'd5);
        push(32'h1, 4'd0);
        push(32'h1, 4'd1);
        pulse_irq(64'h1_0000_0001, k);
        wait_int(c); respond(1'b1, 1'b0, 1);
        wait_int(c); respond(1'b1, 1'b0, 1);
        chk("rr_both_cleared", irq_pending, 64'h0);

        // RR alternation plus lowest-vector priority; f1 mm=1 folds vector 9 to bit 1
        set_mm(3'd5, 3'd1);
        push(32'h10, 4'd0);
        push(32'h2, 4'd1);
        push(32'h80, 4'd0);
        pulse_irq((64'h1 << 41) | 64'h90, k);
        for (int i = 0; i < 3; i++) begin
            wait_int(c); respond(1'b1, 1'b0, 1);
        end
        chk("rr_mix_cleared", irq_pending, 64'h0);

        // Fail on every attempt: three issues, then drop; fail cycle -> reissue is RD+1
        set_mm(3'd5, 3'd5);
        d0 = drop_seen;
        repeat (3) push(32'h2, 4'd0);
        pulse_irq(64'h2, k);
        wait_int(c1); respond(1'b0, 1'b1, 1);
        wait_int(c2); chk("fail_gap1", 64'(c2 - c1), 64'(RD + 2));
        respond(1'b0, 1'b1, 1);
        wait_int(c3); chk("fail_gap2", 64'(c3 - c2), 64'(RD + 2));
        respond(1'b0, 1'b1, 1);
        @(negedge clk);
        chk("drop_count", 64'(drop_seen - d0), 64'd1);
        chk("drop_one_cycle", 64'(irq_drop), 64'h0);
        chk("drop_pending", irq_pending, 64'h0);
        repeat (12) @(negedge clk);

        // No response: reissue after ISSUE + WT + RD
        repeat (2) push(32'h4, 4'd0);
        pulse_irq(64'h4, k);
        wait_int(c1);
        wait_int(c2);
        chk("timeout_gap", 64'(c2 - c1), 64'(WT + RD + 1));
        respond(1'b1, 1'b0, 1);
        chk("timeout_cleared", irq_pending, 64'h0);

        // Disabled function holds its pending bit until enabled
        bus.cfg_interrupt_msi_enable = 4'b0010;
        pulse_irq(64'h20, k);
        repeat (10) @(negedge clk);
        chk("disabled_held", irq_pending, 64'h20);
        push(32'h20, 4'd0);
        bus.cfg_interrupt_msi_enable = 4'b0011;
        wait_int(c); respond(1'b1, 1'b0, 1);
        chk("enabled_cleared", irq_pending, 64'h0);

        // Disable while backing off: request is still reissued
        repeat (2) push(32'h1, 4'd0);
        pulse_irq(64'h1, k);
        wait_int(c);
        respond(1'b0, 1'b1, 1);
        bus.cfg_interrupt_msi_enable = 4'b0010;
        wait_int(c); respond(1'b1, 1'b0, 1);
        chk("backoff_disabled_cleared", irq_pending, 64'h0);
        bus.cfg_interrupt_msi_enable = 4'b0011;

        // Same-cycle clear and new event: bit stays, reissued; sent+fail counts as sent
        d0 = drop_seen;
        repeat (2) push(32'h100, 4'd0);
        pulse_irq(64'h100, k);
        wait_int(c);
        @(negedge clk);
        bus.cfg_interrupt_msi_sent = 1'b1;
        irq_in = 64'h100;
        @(negedge clk);
        bus.cfg_interrupt_msi_sent = 1'b0;
        irq_in = '0;
        chk("set_wins", irq_pending, 64'h100);
        wait_int(c);
        respond(1'b1, 1'b1, 1);
        chk("sent_and_fail", irq_pending, 64'h0);
        repeat (15) @(negedge clk);
        chk("sent_and_fail_nodrop", 64'(drop_seen - d0), 64'd0);

        // Reset during WAIT aborts; a later sent is ignored
        push(32'h8, 4'd0);
        pulse_irq(64'h8, k);
        wait_int(c);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("rst_wait_int", 64'(bus.cfg_interrupt_msi_int), 64'h0);
        chk("rst_wait_pending", irq_pending, 64'h0);
        rst = 1'b0;
        respond(1'b1, 1'b0, 0);
        repeat (5) @(negedge clk);
        chk("post_rst_pending", irq_pending, 64'h0);
        push(32'h10, 4'd0);
        pulse_irq(64'h10, k);
        wait_int(c); respond(1'b1, 1'b0, 1);
        chk("post_rst_served", irq_pending, 64'h0);

        repeat (5) @(negedge clk);
        chk("queue_empty", 64'(exp_q.size()), 64'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $display("test done: total=%0d bad=%0d", total, bad + 1);
        $fatal(1);
    end

endmodule
